// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, state encoding and
// control-word field codes. MC_ADDI_EN adds the addi execute/write-back states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecute,
        StRWb,
        StBranch,
        StJump
`ifdef MC_ADDI_EN
        ,
        StAddiExec,
        StAddiWb
`endif
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

    // States that wait on the memory handshake and are covered by the watchdog.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore decode of the control state into the datapath control word.
// mem_ready only qualifies the handshake-completion outputs of FETCH and MEM_WRITE.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_state)
            StFetch: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                o_ctrl.alu_src_b = ALUSRCB_IMM_SH;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            StMemAddr: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            StMemRead: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            StMemWrite: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.i_or_d     = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            StExecute: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            StRWb: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            StBranch: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALUSRCB_REG;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            StJump: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            StAddiExec: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            StAddiWb: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM and memory watchdog for the multicycle MIPS datapath.
// Define MC_ADDI_EN to make opcode 001000 (addi) legal.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_ready,
    input  logic [5:0] Opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       InstrDone,
    output logic [1:0] Fault
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam bit WdogEn = (TIMEOUT != 0);

    state_e          r_state;
    state_e          w_state_d;
    logic [CntW-1:0] r_wait;
    logic [CntW-1:0] w_wait_d;
    logic            w_wait_state;
    logic            w_timeout;
    logic            w_we_ok;
    logic [1:0]      w_fault;
    ctrl_t           w_ctrl;

    assign w_wait_state = is_mem_wait_state(r_state);
    // A completing handshake on the deadline cycle takes priority over the timeout.
    assign w_timeout = WdogEn && w_wait_state && !mem_ready && (r_wait == TimeoutCnt);

    always_comb begin
        w_state_d = r_state;
        w_fault   = FAULT_NONE;
        unique case (r_state)
            StFetch: if (mem_ready) w_state_d = StDecode;
            StDecode: begin
                unique case (Opcode)
                    OP_LW, OP_SW: w_state_d = StMemAddr;
                    OP_RTYPE:     w_state_d = StExecute;
                    OP_BEQ:       w_state_d = StBranch;
                    OP_J:         w_state_d = StJump;
`ifdef MC_ADDI_EN
                    OP_ADDI:      w_state_d = StAddiExec;
`endif
                    default: begin
                        w_state_d = StFetch;
                        w_fault   = FAULT_ILLEGAL;
                    end
                endcase
            end
            StMemAddr:  w_state_d = (Opcode == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) w_state_d = StMemWb;
            StMemWrite: if (mem_ready) w_state_d = StFetch;
            StExecute:  w_state_d = StRWb;
`ifdef MC_ADDI_EN
            StAddiExec: w_state_d = StAddiWb;
`endif
            default:    w_state_d = StFetch;
        endcase
        if (w_timeout) begin
            w_state_d = StFetch;
            w_fault   = FAULT_TIMEOUT;
        end
    end

    // Clearing on timeout as well lets a FETCH timeout restart with a fresh budget.
    always_comb begin
        w_wait_d = r_wait;
        if ((w_state_d != r_state) || w_timeout) begin
            w_wait_d = '0;
        end else if (w_wait_state && !mem_ready && (r_wait != TimeoutCnt)) begin
            w_wait_d = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
        end
    end

    mc_output_decode u_output_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign w_we_ok = rst_n && !w_timeout;

    assign PCWrite     = w_ctrl.pc_write & w_we_ok;
    assign PCWriteCond = w_ctrl.pc_write_cond & w_we_ok;
    assign IorD        = w_ctrl.i_or_d;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write & w_we_ok;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign IRWrite     = w_ctrl.ir_write & w_we_ok;
    assign PCSource    = w_ctrl.pc_source;
    assign ALUOp       = w_ctrl.alu_op;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign RegWrite    = w_ctrl.reg_write & w_we_ok;
    assign RegDst      = w_ctrl.reg_dst;
    assign InstrDone   = w_ctrl.instr_done;
    assign Fault       = w_fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (TIMEOUT=4): per-cycle control-word checks.
// Expectations for opcode 001000 follow MC_ADDI_EN.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic       mem_ready;
    logic [5:0] Opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB, Fault;
    logic       ALUSrcA, RegWrite, RegDst, InstrDone;

    int n_checks;
    int n_fail;

    multicycle_control #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_ready   (mem_ready),
        .Opcode      (Opcode),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .InstrDone   (InstrDone),
        .Fault       (Fault)
    );

    // Observed word: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
    //                PCSource ALUOp ALUSrcA ALUSrcB RegWrite RegDst InstrDone Fault
    logic [18:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, InstrDone, Fault};

    localparam logic [18:0] E_FETCH_R  = 19'b1_0_0_1_0_0_1_00_00_0_01_0_0_0_00;
    localparam logic [18:0] E_FETCH_W  = 19'b0_0_0_1_0_0_0_00_00_0_01_0_0_0_00;
    localparam logic [18:0] E_FETCH_TO = 19'b0_0_0_1_0_0_0_00_00_0_01_0_0_0_10;
    localparam logic [18:0] E_DECODE   = 19'b0_0_0_0_0_0_0_00_00_0_11_0_0_0_00;
    localparam logic [18:0] E_DEC_ILL  = 19'b0_0_0_0_0_0_0_00_00_0_11_0_0_0_01;
    localparam logic [18:0] E_MEMADDR  = 19'b0_0_0_0_0_0_0_00_00_1_10_0_0_0_00;
    localparam logic [18:0] E_MEMREAD  = 19'b0_0_1_1_0_0_0_00_00_0_00_0_0_0_00;
    localparam logic [18:0] E_MEMRD_TO = 19'b0_0_1_1_0_0_0_00_00_0_00_0_0_0_10;
    localparam logic [18:0] E_MEMWB    = 19'b0_0_0_0_0_1_0_00_00_0_00_1_0_1_00;
    localparam logic [18:0] E_MEMWR_W  = 19'b0_0_1_0_1_0_0_00_00_0_00_0_0_0_00;
    localparam logic [18:0] E_MEMWR_R  = 19'b0_0_1_0_1_0_0_00_00_0_00_0_0_1_00;
    localparam logic [18:0] E_MEMWR_TO = 19'b0_0_1_0_0_0_0_00_00_0_00_0_0_0_10;
    localparam logic [18:0] E_EXEC     = 19'b0_0_0_0_0_0_0_00_10_1_00_0_0_0_00;
    localparam logic [18:0] E_RWB      = 19'b0_0_0_0_0_0_0_00_00_0_00_1_1_1_00;
    localparam logic [18:0] E_BRANCH   = 19'b0_1_0_0_0_0_0_01_01_1_00_0_0_1_00;
    localparam logic [18:0] E_JUMP     = 19'b1_0_0_0_0_0_0_10_00_0_00_0_0_1_00;
    localparam logic [18:0] E_ADDIEX   = 19'b0_0_0_0_0_0_0_00_00_1_10_0_0_0_00;
    localparam logic [18:0] E_ADDIWB   = 19'b0_0_0_0_0_0_0_00_00_0_00_1_0_1_00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", tag, got[18:0], exp[18:0]);
        end
    endtask

    // Called just after a rising edge: drive mem_ready, check at the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input logic rdy, input logic [18:0] exp);
        mem_ready = rdy;
        @(negedge clk);
        check_eq(tag, {13'd0, obs}, {13'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        Opcode    = 6'b000000;
        #3;
        check_eq("reset", {13'd0, obs}, {13'd0, E_FETCH_W});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw, no wait states: 5 cycles
        Opcode = 6'b100011;
        step("lw_fetch", 1'b1, E_FETCH_R);
        step("lw_decode", 1'b1, E_DECODE);
        step("lw_addr", 1'b1, E_MEMADDR);
        step("lw_read", 1'b1, E_MEMREAD);
        step("lw_wb", 1'b1, E_MEMWB);

        // R-type with mem_ready low outside memory states (must be ignored)
        Opcode = 6'b000000;
        step("r_fetch", 1'b1, E_FETCH_R);
        step("r_decode", 1'b0, E_DECODE);
        step("r_exec", 1'b0, E_EXEC);
        step("r_wb", 1'b0, E_RWB);

        // beq then j, back-to-back
        Opcode = 6'b000100;
        step("beq_fetch", 1'b1, E_FETCH_R);
        step("beq_decode", 1'b1, E_DECODE);
        step("beq_branch", 1'b1, E_BRANCH);
        Opcode = 6'b000010;
        step("j_fetch", 1'b0, E_FETCH_W);
        step("j_fetch_rdy", 1'b1, E_FETCH_R);
        step("j_decode", 1'b1, E_DECODE);
        step("j_jump", 1'b1, E_JUMP);

        // sw with 3 wait states: MemWrite for 4 cycles, 7 total, one InstrDone
        Opcode = 6'b101011;
        step("sw_fetch", 1'b1, E_FETCH_R);
        step("sw_decode", 1'b1, E_DECODE);
        step("sw_addr", 1'b1, E_MEMADDR);
        for (int i = 0; i < 3; i++) step("sw_wait", 1'b0, E_MEMWR_W);
        step("sw_done", 1'b1, E_MEMWR_R);

        // lw stuck in MEM_READ: timeout after 4 wait cycles, no RegWrite
        Opcode = 6'b100011;
        step("lwto_fetch", 1'b1, E_FETCH_R);
        step("lwto_decode", 1'b1, E_DECODE);
        step("lwto_addr", 1'b1, E_MEMADDR);
        for (int i = 0; i < 4; i++) step("lwto_wait", 1'b0, E_MEMREAD);
        step("lwto_fault", 1'b0, E_MEMRD_TO);

        // Fetch timeout restarts the fetch with a fresh budget
        for (int i = 0; i < 4; i++) step("fto_wait", 1'b0, E_FETCH_W);
        step("fto_fault", 1'b0, E_FETCH_TO);
        for (int i = 0; i < 4; i++) step("fto_rewait", 1'b0, E_FETCH_W);

        // mem_ready arriving on the deadline cycle wins over the timeout
        step("race_fetch", 1'b1, E_FETCH_R);
        step("race_decode", 1'b1, E_DECODE);
        step("race_addr", 1'b1, E_MEMADDR);
        for (int i = 0; i < 4; i++) step("race_wait", 1'b0, E_MEMREAD);
        step("race_ready", 1'b1, E_MEMREAD);
        step("race_wb", 1'b1, E_MEMWB);

        // sw timeout: MemWrite suppressed on the fault cycle
        Opcode = 6'b101011;
        step("swto_fetch", 1'b1, E_FETCH_R);
        step("swto_decode", 1'b1, E_DECODE);
        step("swto_addr", 1'b1, E_MEMADDR);
        for (int i = 0; i < 4; i++) step("swto_wait", 1'b0, E_MEMWR_W);
        step("swto_fault", 1'b0, E_MEMWR_TO);

        // addi: legal only with MC_ADDI_EN
        Opcode = 6'b001000;
        step("addi_fetch", 1'b1, E_FETCH_R);
`ifdef MC_ADDI_EN
        step("addi_decode", 1'b1, E_DECODE);
        step("addi_exec", 1'b1, E_ADDIEX);
        step("addi_wb", 1'b1, E_ADDIWB);
`else
        step("addi_illegal", 1'b1, E_DEC_ILL);
`endif

        // Illegal opcode, then async reset during EXECUTE of an R-type
        Opcode = 6'b111111;
        step("ill_fetch", 1'b1, E_FETCH_R);
        step("ill_decode", 1'b1, E_DEC_ILL);
        Opcode = 6'b000000;
        step("rr_fetch", 1'b1, E_FETCH_R);
        step("rr_decode", 1'b1, E_DECODE);
        mem_ready = 1'b1;
        #1;
        check_eq("rr_exec", {13'd0, obs}, {13'd0, E_EXEC});
        rst_n = 1'b0;
        #1;
        check_eq("rr_async_rst", {13'd0, obs}, {13'd0, E_FETCH_W});
        @(posedge clk);
        #1;
        check_eq("rr_rst_held", {13'd0, obs}, {13'd0, E_FETCH_W});
        rst_n = 1'b1;
        step("rr_refetch", 1'b1, E_FETCH_R);
        step("rr_redecode", 1'b1, E_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back steps, and drives every datapath enable and mux select. It is also the producer of the 2-bit `ALUOp` code consumed by the ALU control decoder: `00` add, `01` subtract, `10` decode funct. Memory accesses use a ready handshake so that wait-state memories are supported.

## Interface
- `TIMEOUT`, default 16: maximum wait cycles allowed in any memory state; 0 disables the watchdog.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `Opcode` in 6: instruction register bits [31:26], valid from DECODE onward.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by the ALU Zero flag (beq).
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `MemtoReg` out 1: register write data; 0 = ALUOut, 1 = MDR.
- `IRWrite` out 1: instruction register load.
- `PCSource` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp` out 2: 00 add, 01 subtract, 10 funct decode; 11 is never driven.
- `ALUSrcA` out 1: ALU A input; 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B input; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `RegWrite` out 1: register file write enable.
- `RegDst` out 1: destination register; 0 = rt, 1 = rd.
- `InstrDone` out 1: one-cycle pulse on the final cycle of each retired instruction.
- `Fault` out 2: one-cycle pulse on abort; 01 = illegal opcode, 10 = memory timeout.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP. ADDI_EXEC and ADDI_WB exist only when the configuration macro is defined.
- Outputs are Moore outputs decoded from the state. `PCWrite`, `IRWrite`, `RegWrite` and `MemWrite` are combinationally forced to 0 while `rst_n` is low.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - The FSM leaves FETCH for DECODE only when `mem_ready`=1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) and 101011 (sw) → MEM_ADDR.
  - 000000 → EXECUTE.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - 001000 → ADDI_EXEC when configured.
  - Any other opcode → FETCH, with `Fault`=01 for one cycle.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `MemRead`=1, `IorD`=1. Holds until `mem_ready`, then → MEM_WB.
- MEM_WB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `InstrDone`=1. → FETCH.
- MEM_WRITE: `MemWrite`=1, `IorD`=1. Holds until `mem_ready`; on that cycle `InstrDone`=1, then → FETCH.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. → R_WB.
- R_WB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `InstrDone`=1. → FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01, `InstrDone`=1. → FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10, `InstrDone`=1. → FETCH.
- Any output not listed for a state is 0.
- Watchdog: a wait counter clears on every state change and increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with `mem_ready`=0. When it reaches `TIMEOUT`:
  - `Fault`=10 for one cycle and the state goes to FETCH; no write enable is asserted on that cycle.
  - A timeout inside FETCH restarts the fetch.

## Timing
- Reset: state FETCH, wait counter 0, `Fault`=00, `InstrDone`=0. All other outputs take their FETCH values, with the write enables forced 0 while `rst_n` is low.
- Latency with zero wait states: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle with `mem_ready`=0 in a memory state adds one cycle.
- `mem_ready` is sampled only in FETCH, MEM_READ and MEM_WRITE, and ignored elsewhere.
- Asserting `rst_n` low mid-instruction returns the FSM to FETCH immediately; no partial write occurs after the reset edge.
- If `mem_ready` rises on the same cycle the counter hits `TIMEOUT`, `mem_ready` wins: normal transition, no fault.

## Configuration
- `MC_ADDI_EN` defined:
  - ADDI_EXEC: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
  - ADDI_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0, `InstrDone`=1.
  - Opcode 001000 is legal.
- `MC_ADDI_EN` undefined: both states are absent, and 001000 is treated as illegal (`Fault`=01).

## Structure
- Shared package `mips_ctrl_pkg`: opcode constants, state encoding, `ALUOp` codes (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10), `PCSource` and `ALUSrcB` codes, `Fault` codes.
- One sub-module, `mc_output_decode`: purely combinational, maps state plus `mem_ready` to the control word. The FSM and watchdog stay in the top level.

## Test plan
- lw (Opcode 100011), `mem_ready` always 1 → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; `RegWrite`=1 with `MemtoReg`=1 in cycle 5; `InstrDone` pulse in cycle 5.
- R-type (000000) → `ALUOp`=10 in EXECUTE; `RegWrite`=1, `RegDst`=1 in R_WB; 4 cycles total.
- beq (000100) → `ALUOp`=01 and `PCWriteCond`=1 in cycle 3; back to FETCH in cycle 4.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `MemWrite` held 4 cycles; 7 cycles total; exactly one `InstrDone`.
- `TIMEOUT`=4, `mem_ready` stuck at 0 in MEM_READ → `Fault`=10 after 4 wait cycles, next state FETCH, `RegWrite` never asserted.
- Opcode 111111, then `rst_n` pulsed low during EXECUTE of the next R-type → `Fault`=01 one cycle, then the FSM returns to FETCH asynchronously with all write enables 0.
